psum_drain: RTL

PSUM_DRAIN -- requirements
Module: psum_drain

---
 rtl/psum_drain_pkg.sv | 15 +
 rtl/row_fifo.sv | 80 ++++++++
 rtl/psum_drain.sv | 121 ++++++++++++
 3 files changed

// File: rtl/psum_drain_pkg.sv
// Shared array package: geometry constants of the processing-element array and
// small helpers used by the drain logic.
package psum_drain_pkg;

  // Partial-sum width produced by each PE column.
  localparam int unsigned ArrayDataWidth = 16;
  // Number of PE columns feeding the bottom edge of the array.
  localparam int unsigned ArrayNumCols   = 4;

  // Width of an index register able to hold 0..n-1 (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/row_fifo.sv
// row_fifo: synchronous FIFO holding whole aligned rows.
//   clk_i     - clock, all state on rising edge
//   rst_ni    - synchronous active-low reset (clears pointers, count and storage)
//   wr_en_i   - write request; accepted when not full, or when full with a read
//   wr_data_i - row to write
//   rd_en_i   - read request; honoured only when not empty
//   rd_data_o - row at the head (registered storage, no write bypass)
//   full_o    - Depth rows buffered
//   empty_o   - no rows buffered
//   count_o   - rows currently buffered
module row_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_wr, do_rd;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;

  assign do_rd = rd_en_i && !empty_o;
  // A full FIFO still takes a write when the head leaves in the same cycle;
  // the write slot then coincides with the slot being freed.
  assign do_wr = wr_en_i && (!full_o || do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Depth is a power of two, so pointers wrap naturally.
    if (do_wr) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/psum_drain.sv
// psum_drain: deskews the bottom-row outputs of the PE array into whole rows,
// buffers them in a row FIFO and presents them on a valid/ready interface,
// flagging the last row of each result tile.
//   clk        - clock, all state on rising edge
//   reset      - synchronous active-low reset
//   in_psum    - skewed column data; column c at [c*DATA_WIDTH +: DATA_WIDTH]
//   in_valid   - column 0 of a row is present this cycle
//   out_data   - deskewed row, same packing
//   out_valid  - out_data holds a row
//   out_ready  - consumer takes the row
//   out_last   - presented row is the last of its tile
//   overflow   - sticky, a row was dropped because the FIFO was full
//   fifo_count - rows currently buffered
module psum_drain
  import psum_drain_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ArrayDataWidth,
  parameter int unsigned NUM_COLS   = ArrayNumCols,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned NUM_ROWS   = 4,
  localparam int unsigned RowW      = NUM_COLS * DATA_WIDTH,
  localparam int unsigned CntW      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RowW-1:0] in_psum,
  input  logic            in_valid,
  output logic [RowW-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic            overflow,
  output logic [CntW-1:0] fifo_count
);

  localparam int unsigned RowIdxW = idx_width(NUM_ROWS);
  localparam logic [RowIdxW-1:0] LastIdx = RowIdxW'(NUM_ROWS - 1);

  logic [RowW-1:0] aligned_row;
  logic            aligned_valid;
  logic            fifo_full, fifo_empty;
  logic            pop;
  logic            ovf_q, ovf_d;
  logic [RowIdxW-1:0] row_idx_q, row_idx_d;

  // Column c arrives c cycles after column 0, so it is delayed by the
  // remaining NUM_COLS-1-c cycles; the last column needs no delay at all.
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    localparam int unsigned Delay = NUM_COLS - 1 - c;
    if (Delay == 0) begin : g_direct
      assign aligned_row[c*DATA_WIDTH +: DATA_WIDTH] = in_psum[c*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] pipe_q [Delay];
      always_ff @(posedge clk) begin
        if (!reset) begin
          for (int k = 0; k < int'(Delay); k++) pipe_q[k] <= '0;
        end else begin
          pipe_q[0] <= in_psum[c*DATA_WIDTH +: DATA_WIDTH];
          for (int k = 1; k < int'(Delay); k++) pipe_q[k] <= pipe_q[k-1];
        end
      end
      assign aligned_row[c*DATA_WIDTH +: DATA_WIDTH] = pipe_q[Delay-1];
    end
  end

  // Row strobe follows column 0 through the same NUM_COLS-1 stages.
  if (NUM_COLS == 1) begin : g_vld_direct
    assign aligned_valid = in_valid;
  end else begin : g_vld_delay
    logic vld_q [NUM_COLS-1];
    always_ff @(posedge clk) begin
      if (!reset) begin
        for (int k = 0; k < int'(NUM_COLS) - 1; k++) vld_q[k] <= 1'b0;
      end else begin
        vld_q[0] <= in_valid;
        for (int k = 1; k < int'(NUM_COLS) - 1; k++) vld_q[k] <= vld_q[k-1];
      end
    end
    assign aligned_valid = vld_q[NUM_COLS-2];
  end

  row_fifo #(
    .Width (RowW),
    .Depth (FIFO_DEPTH)
  ) u_row_fifo (
    .clk_i     (clk),
    .rst_ni    (reset),
    .wr_en_i   (aligned_valid),
    .wr_data_i (aligned_row),
    .rd_en_i   (pop),
    .rd_data_o (out_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  always_comb begin
    ovf_d     = ovf_q;
    row_idx_d = row_idx_q;
    // Drop happens only when full and the head is not leaving this cycle.
    if (aligned_valid && fifo_full && !pop) ovf_d = 1'b1;
    if (pop) row_idx_d = (row_idx_q == LastIdx) ? '0 : row_idx_q + RowIdxW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf_q     <= 1'b0;
      row_idx_q <= '0;
    end else begin
      ovf_q     <= ovf_d;
      row_idx_q <= row_idx_d;
    end
  end

  assign overflow = ovf_q;
  assign out_last = out_valid && (row_idx_q == LastIdx);

endmodule
